ring_stop_mc: RTL and testbench

- Parametrised multi-channel ring stop. Generalises the fixed per-tile ring hookup into one reusable stop with configurable local channel count and per-channel injection buffering.
- Sits between ring segment N (input) and N+1 (output); NUM_TILE instances of it, chained in a closed loop, form the request ring.
- Ejects ring packets addressed to this stop, forwards all others, and injects local requests into free slots under round-robin arbitration.

---
 rtl/ring_stop_mc.sv | 228 ++++++++++++++++++++++
 tb/tb_ring_stop_mc.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_stop_mc.sv
// ring_stop_mc: one stop of the request ring; ejects hits, forwards traffic, injects local
// requests round-robin into free slots. Define RING_STOP_STATS_EN for the activity counters.
package ring_stop_mc_pkg;
    typedef logic [3:0] t_opcode;

    typedef struct packed {
        t_opcode     opcode;
        logic [31:0] addr;
        logic [31:0] data;
    } t_req_payload;
endpackage

module ring_stop_mc
    import ring_stop_mc_pkg::*;
#(
    parameter  int unsigned NUM_CH     = 4,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned CORE_ID_W  = 8,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned REQ_W      = CORE_ID_W + CH_W
) (
    input  logic                    QClk,
    input  logic                    RstQnnnL,
    input  logic [CORE_ID_W-1:0]    CoreID,
    input  logic                    RingInValid,
    input  logic [REQ_W-1:0]        RingInRequestor,
    input  t_opcode                 RingInOpcode,
    input  logic [31:0]             RingInAddress,
    input  logic [31:0]             RingInData,
    output logic                    RingOutValid,
    output logic [REQ_W-1:0]        RingOutRequestor,
    output t_opcode                 RingOutOpcode,
    output logic [31:0]             RingOutAddress,
    output logic [31:0]             RingOutData,
    input  logic [NUM_CH-1:0]       LocReqValid,
    output logic [NUM_CH-1:0]       LocReqReady,
    input  t_opcode [NUM_CH-1:0]    LocReqOpcode,
    input  logic [NUM_CH-1:0][31:0] LocReqAddress,
    input  logic [NUM_CH-1:0][31:0] LocReqData,
    output logic                    EjectValid,
    input  logic                    EjectReady,
    output logic [REQ_W-1:0]        EjectRequestor,
    output t_opcode                 EjectOpcode,
    output logic [31:0]             EjectAddress,
    output logic [31:0]             EjectData
`ifdef RING_STOP_STATS_EN
    ,
    output logic [31:0]             StatInjCnt,
    output logic [31:0]             StatEjCnt,
    output logic [31:0]             StatBounceCnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    t_req_payload                  r_mem [NUM_CH][FIFO_DEPTH];
    logic [NUM_CH-1:0][PTR_W-1:0]  r_wptr;
    logic [NUM_CH-1:0][PTR_W-1:0]  r_rptr;
    logic [NUM_CH-1:0][CNT_W-1:0]  r_cnt;
    logic [CH_W-1:0]               r_rr;

    logic                          r_out_valid;
    logic [REQ_W-1:0]              r_out_req;
    t_req_payload                  r_out_pl;
    logic                          r_ej_valid;
    logic [REQ_W-1:0]              r_ej_req;
    t_req_payload                  r_ej_pl;

    logic [NUM_CH-1:0]             w_full;
    logic [NUM_CH-1:0]             w_nonempty;
    logic [NUM_CH-1:0]             w_push;
    logic [NUM_CH-1:0]             w_pop;
    logic                          w_hit;
    logic                          w_ej_ok;
    logic                          w_eject;
    logic                          w_bounce;
    logic                          w_slot_free;
    logic                          w_gnt_valid;
    logic [CH_W-1:0]               w_gnt_idx;
    logic                          w_inject;
    t_req_payload                  w_gnt_pl;
    t_req_payload                  w_ring_in_pl;

    function automatic logic [CH_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // Per-channel FIFO status and enqueue qualification
    always_comb begin
        w_full     = '0;
        w_nonempty = '0;
        w_push     = '0;
        w_pop      = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_full[c]     = (r_cnt[c] == CNT_W'(FIFO_DEPTH));
            w_nonempty[c] = (r_cnt[c] != '0);
            w_push[c]     = LocReqValid[c] && !w_full[c];
            w_pop[c]      = w_inject && (w_gnt_idx == CH_W'(c));
        end
    end

    assign LocReqReady = ~w_full;

    assign w_hit        = RingInValid && (RingInAddress[31 -: CORE_ID_W] == CoreID);
    assign w_ej_ok      = !r_ej_valid || EjectReady;
    assign w_eject      = w_hit && w_ej_ok;
    assign w_bounce     = w_hit && !w_ej_ok;
    assign w_slot_free  = !RingInValid || w_eject;
    assign w_inject     = w_slot_free && w_gnt_valid;
    assign w_ring_in_pl = '{opcode: RingInOpcode, addr: RingInAddress, data: RingInData};

    // Round-robin search: first non-empty channel at or after the pointer
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!w_gnt_valid && w_nonempty[wrap_idx(32'(r_rr), i)]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = wrap_idx(32'(r_rr), i);
            end
        end
    end

    assign w_gnt_pl = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];

    always_ff @(posedge QClk) begin
        if (!RstQnnnL) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (w_push[c]) r_wptr[c] <= PTR_W'(r_wptr[c] + PTR_W'(1));
                if (w_pop[c])  r_rptr[c] <= PTR_W'(r_rptr[c] + PTR_W'(1));
                if (w_push[c] && !w_pop[c])      r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                else if (!w_push[c] && w_pop[c]) r_cnt[c] <= r_cnt[c] - CNT_W'(1);
            end
        end
    end

    // Storage is left unreset; the pointers alone define validity
    always_ff @(posedge QClk) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_push[c]) begin
                r_mem[c][r_wptr[c]] <= '{opcode: LocReqOpcode[c],
                                         addr:   LocReqAddress[c],
                                         data:   LocReqData[c]};
            end
        end
    end

    always_ff @(posedge QClk) begin
        if (!RstQnnnL) begin
            r_out_valid <= 1'b0;
            r_out_req   <= '0;
            r_out_pl    <= '0;
            r_rr        <= '0;
        end else if (!w_slot_free) begin
            r_out_valid <= 1'b1;
            r_out_req   <= RingInRequestor;
            r_out_pl    <= w_ring_in_pl;
        end else if (w_inject) begin
            r_out_valid <= 1'b1;
            r_out_req   <= {CoreID, w_gnt_idx};
            r_out_pl    <= w_gnt_pl;
            r_rr        <= wrap_idx(32'(w_gnt_idx), 1);
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // Eject register holds until consumed; a same-cycle reload wins over the clear
    always_ff @(posedge QClk) begin
        if (!RstQnnnL) begin
            r_ej_valid <= 1'b0;
            r_ej_req   <= '0;
            r_ej_pl    <= '0;
        end else if (w_eject) begin
            r_ej_valid <= 1'b1;
            r_ej_req   <= RingInRequestor;
            r_ej_pl    <= w_ring_in_pl;
        end else if (EjectReady) begin
            r_ej_valid <= 1'b0;
        end
    end

    assign RingOutValid     = r_out_valid;
    assign RingOutRequestor = r_out_req;
    assign RingOutOpcode    = r_out_pl.opcode;
    assign RingOutAddress   = r_out_pl.addr;
    assign RingOutData      = r_out_pl.data;
    assign EjectValid       = r_ej_valid;
    assign EjectRequestor   = r_ej_req;
    assign EjectOpcode      = r_ej_pl.opcode;
    assign EjectAddress     = r_ej_pl.addr;
    assign EjectData        = r_ej_pl.data;

`ifdef RING_STOP_STATS_EN
    logic [31:0] r_inj_cnt;
    logic [31:0] r_ej_cnt;
    logic [31:0] r_bnc_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge QClk) begin
        if (!RstQnnnL) begin
            r_inj_cnt <= '0;
            r_ej_cnt  <= '0;
            r_bnc_cnt <= '0;
        end else begin
            if (w_inject) r_inj_cnt <= sat_inc(r_inj_cnt);
            if (w_eject)  r_ej_cnt  <= sat_inc(r_ej_cnt);
            if (w_bounce) r_bnc_cnt <= sat_inc(r_bnc_cnt);
        end
    end

    assign StatInjCnt    = r_inj_cnt;
    assign StatEjCnt     = r_ej_cnt;
    assign StatBounceCnt = r_bnc_cnt;
`endif

endmodule

// File: tb/tb_ring_stop_mc.sv
// tb_ring_stop_mc: directed stimulus with a queue-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_ring_stop_mc;
    import ring_stop_mc_pkg::*;

    localparam int unsigned NCH   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned CHW   = 2;
    localparam int unsigned RW    = CW + CHW;

    logic                 QClk = 1'b0;
    logic                 RstQnnnL;
    logic [CW-1:0]        CoreID;
    logic                 RingInValid;
    logic [RW-1:0]        RingInRequestor;
    t_opcode              RingInOpcode;
    logic [31:0]          RingInAddress;
    logic [31:0]          RingInData;
    logic                 RingOutValid;
    logic [RW-1:0]        RingOutRequestor;
    t_opcode              RingOutOpcode;
    logic [31:0]          RingOutAddress;
    logic [31:0]          RingOutData;
    logic [NCH-1:0]       LocReqValid;
    logic [NCH-1:0]       LocReqReady;
    t_opcode [NCH-1:0]    LocReqOpcode;
    logic [NCH-1:0][31:0] LocReqAddress;
    logic [NCH-1:0][31:0] LocReqData;
    logic                 EjectValid;
    logic                 EjectReady;
    logic [RW-1:0]        EjectRequestor;
    t_opcode              EjectOpcode;
    logic [31:0]          EjectAddress;
    logic [31:0]          EjectData;
`ifdef RING_STOP_STATS_EN
    logic [31:0]          StatInjCnt;
    logic [31:0]          StatEjCnt;
    logic [31:0]          StatBounceCnt;
`endif

    always #5 QClk = ~QClk;

    ring_stop_mc #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .CORE_ID_W(CW)) dut (
        .QClk(QClk), .RstQnnnL(RstQnnnL), .CoreID(CoreID),
        .RingInValid(RingInValid), .RingInRequestor(RingInRequestor), .RingInOpcode(RingInOpcode),
        .RingInAddress(RingInAddress), .RingInData(RingInData),
        .RingOutValid(RingOutValid), .RingOutRequestor(RingOutRequestor), .RingOutOpcode(RingOutOpcode),
        .RingOutAddress(RingOutAddress), .RingOutData(RingOutData),
        .LocReqValid(LocReqValid), .LocReqReady(LocReqReady), .LocReqOpcode(LocReqOpcode),
        .LocReqAddress(LocReqAddress), .LocReqData(LocReqData),
        .EjectValid(EjectValid), .EjectReady(EjectReady), .EjectRequestor(EjectRequestor),
        .EjectOpcode(EjectOpcode), .EjectAddress(EjectAddress), .EjectData(EjectData)
`ifdef RING_STOP_STATS_EN
        , .StatInjCnt(StatInjCnt), .StatEjCnt(StatEjCnt), .StatBounceCnt(StatBounceCnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel, a slot-level view of the ring
    t_req_payload  m_q [NCH][$];
    int            m_rr;
    logic          m_out_v;
    logic [RW-1:0] m_out_req;
    t_req_payload  m_out_pl;
    logic          m_ej_v;
    logic [RW-1:0] m_ej_req;
    t_req_payload  m_ej_pl;
    logic [31:0]   m_inj, m_ejc, m_bnc;
    logic [NCH-1:0] m_acc;
    logic          m_hit, m_ejok, m_free;
    int            m_g;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always @(posedge QClk) begin
        if (!RstQnnnL) begin
            for (int c = 0; c < NCH; c++) m_q[c].delete();
            m_rr = 0; m_out_v = 0; m_out_req = '0; m_out_pl = '0;
            m_ej_v = 0; m_ej_req = '0; m_ej_pl = '0;
            m_inj = 0; m_ejc = 0; m_bnc = 0;
        end else begin
            for (int c = 0; c < NCH; c++) m_acc[c] = LocReqValid[c] && (m_q[c].size() < DEPTH);
            m_hit  = RingInValid && (RingInAddress[31 -: CW] == CoreID);
            m_ejok = !m_ej_v || EjectReady;
            m_free = !RingInValid || (m_hit && m_ejok);
            m_g = -1;
            if (m_free)
                for (int i = 0; i < NCH; i++)
                    if (m_g < 0 && m_q[(m_rr + i) % NCH].size() != 0) m_g = (m_rr + i) % NCH;
            if (m_hit && m_ejok) begin
                m_ej_v = 1; m_ej_req = RingInRequestor;
                m_ej_pl = '{RingInOpcode, RingInAddress, RingInData};
                m_ejc = sat_inc(m_ejc);
            end else if (EjectReady) begin
                m_ej_v = 0;
            end
            if (m_hit && !m_ejok) m_bnc = sat_inc(m_bnc);
            if (!m_free) begin
                m_out_v = 1; m_out_req = RingInRequestor;
                m_out_pl = '{RingInOpcode, RingInAddress, RingInData};
            end else if (m_g >= 0) begin
                m_out_v = 1; m_out_req = {CoreID, CHW'(m_g)};
                m_out_pl = m_q[m_g].pop_front();
                m_rr = (m_g + 1) % NCH;
                m_inj = sat_inc(m_inj);
            end else begin
                m_out_v = 0;
            end
            for (int c = 0; c < NCH; c++)
                if (m_acc[c]) m_q[c].push_back('{LocReqOpcode[c], LocReqAddress[c], LocReqData[c]});
        end
    end

    // Per-cycle comparison against the model, 1ns after each active edge
    initial begin : compare
        logic [NCH-1:0] exp_rdy;
        @(posedge QClk);
        forever begin
            #1;
            for (int c = 0; c < NCH; c++) exp_rdy[c] = (m_q[c].size() < DEPTH);
            chk("m_ready", LocReqReady, exp_rdy);
            chk("m_out_v", RingOutValid, m_out_v);
            if (m_out_v) begin
                chk("m_out_req", RingOutRequestor, m_out_req);
                chk("m_out_op", RingOutOpcode, m_out_pl.opcode);
                chk("m_out_addr", RingOutAddress, m_out_pl.addr);
                chk("m_out_data", RingOutData, m_out_pl.data);
            end
            chk("m_ej_v", EjectValid, m_ej_v);
            if (m_ej_v) begin
                chk("m_ej_req", EjectRequestor, m_ej_req);
                chk("m_ej_op", EjectOpcode, m_ej_pl.opcode);
                chk("m_ej_addr", EjectAddress, m_ej_pl.addr);
                chk("m_ej_data", EjectData, m_ej_pl.data);
            end
`ifdef RING_STOP_STATS_EN
            chk("m_st_inj", StatInjCnt, m_inj);
            chk("m_st_ej", StatEjCnt, m_ejc);
            chk("m_st_bnc", StatBounceCnt, m_bnc);
`endif
            @(posedge QClk);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step();
        @(posedge QClk);
        #1;
    endtask

    initial begin : stim
        RstQnnnL = 1'b0; CoreID = 8'h01;
        RingInValid = 1'b0; RingInRequestor = '0; RingInOpcode = '0; RingInAddress = '0; RingInData = '0;
        LocReqValid = 4'hF; LocReqOpcode = '0; LocReqAddress = '0; LocReqData = '0;
        EjectReady = 1'b0;

        // Reset held two cycles with all channels requesting
        step(); step();
        chk("rst_ring_v", RingOutValid, 0);
        chk("rst_ej_v", EjectValid, 0);
        @(negedge QClk); RstQnnnL = 1'b1; LocReqValid = '0;
        step();
        chk("rst_ready", LocReqReady, 4'hF);
        chk("rst_noinj", RingOutValid, 0);

        // Pass-through of a foreign packet
        @(negedge QClk);
        RingInValid = 1'b1; RingInRequestor = 10'h155; RingInOpcode = 4'h2;
        RingInAddress = 32'h0200_0010; RingInData = 32'hDEAD_BEEF;
        step();
        chk("pt_v", RingOutValid, 1);
        chk("pt_req", RingOutRequestor, 10'h155);
        chk("pt_op", RingOutOpcode, 4'h2);
        chk("pt_addr", RingOutAddress, 32'h0200_0010);
        chk("pt_data", RingOutData, 32'hDEAD_BEEF);
        chk("pt_ej", EjectValid, 0);

        // Two back-to-back hits with the consumer stalled
        @(negedge QClk);
        CoreID = 8'h02; RingInAddress = 32'h0200_0000; RingInData = 32'h1111_1111; RingInRequestor = 10'h011;
        step();
        chk("ej_v", EjectValid, 1);
        chk("ej_data", EjectData, 32'h1111_1111);
        chk("ej_slot_free", RingOutValid, 0);
        @(negedge QClk);
        RingInData = 32'h2222_2222; RingInRequestor = 10'h022;
        step();
        chk("ej_stable", EjectData, 32'h1111_1111);
        chk("ej_v_hold", EjectValid, 1);
        chk("bounce_v", RingOutValid, 1);
        chk("bounce_data", RingOutData, 32'h2222_2222);
`ifdef RING_STOP_STATS_EN
        chk("bounce_cnt", StatBounceCnt, 32'd1);
`endif
        @(negedge QClk); RingInValid = 1'b0; EjectReady = 1'b1;
        step();
        chk("ej_drained", EjectValid, 0);

        // Round-robin over four simultaneous single pushes
        @(negedge QClk);
        EjectReady = 1'b0; CoreID = 8'h01; LocReqValid = 4'hF;
        for (int c = 0; c < NCH; c++) begin
            LocReqOpcode[c]  = 4'(c);
            LocReqAddress[c] = 32'h0300_0000 + 32'(c);
            LocReqData[c]    = 32'hA000_0000 + 32'(c);
        end
        step();
        chk("rr_min_latency", RingOutValid, 0);
        @(negedge QClk); LocReqValid = '0;
        for (int c = 0; c < NCH; c++) begin
            step();
            chk("rr_v", RingOutValid, 1);
            chk("rr_req", RingOutRequestor, 10'h004 + 10'(c));
            chk("rr_data", RingOutData, 32'hA000_0000 + 32'(c));
        end
        step();
        chk("rr_idle", RingOutValid, 0);

        // Backpressure on channel 2 under continuous foreign traffic
        for (int k = 1; k <= 4; k++) begin
            @(negedge QClk);
            RingInValid = 1'b1; RingInAddress = 32'h0500_0000; RingInRequestor = 10'h3FF;
            RingInData = 32'h5555_0000 + 32'(k);
            LocReqValid = 4'b0100; LocReqAddress[2] = 32'h0600_0000; LocReqData[2] = 32'hC0DE_0000 + 32'(k);
            step();
        end
        chk("bp_full", LocReqReady[2], 0);
        @(negedge QClk); LocReqData[2] = 32'hC0DE_0005;
        step();
        chk("bp_hold", LocReqReady[2], 0);
        chk("bp_fwd_data", RingOutData, 32'h5555_0004);
        @(negedge QClk); RingInValid = 1'b0;
        step();
        chk("bp_inj_v", RingOutValid, 1);
        chk("bp_inj_req", RingOutRequestor, 10'h006);
        chk("bp_inj_data", RingOutData, 32'hC0DE_0001);
        chk("bp_ready_back", LocReqReady[2], 1);
        @(negedge QClk); RingInValid = 1'b1;
        step();
        chk("bp_refull", LocReqReady[2], 0);
        @(negedge QClk); RingInValid = 1'b0; LocReqValid = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_drain_data", RingOutData, 32'hC0DE_0002 + 32'(k));
        end
        step();
        chk("bp_drain_idle", RingOutValid, 0);

        // Reset while FIFOs and eject register hold packets
        @(negedge QClk);
        RingInValid = 1'b1; RingInAddress = 32'h0100_0000; RingInData = 32'hE1E1_E1E1; RingInRequestor = 10'h099;
        step();
        chk("mo_ej_load", EjectValid, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge QClk);
            RingInAddress = 32'h0500_0000; RingInData = 32'h7777_0000 + 32'(k);
            LocReqValid = 4'b0001; LocReqAddress[0] = 32'h0700_0000; LocReqData[0] = 32'hB000_0000 + 32'(k);
            step();
        end
        chk("mo_ej_held", EjectValid, 1);
        @(negedge QClk); RstQnnnL = 1'b0; LocReqValid = '0; RingInValid = 1'b0;
        step();
        chk("mo_ring_v", RingOutValid, 0);
        chk("mo_ej_v", EjectValid, 0);
        chk("mo_ready", LocReqReady, 4'hF);
`ifdef RING_STOP_STATS_EN
        chk("mo_st_inj", StatInjCnt, 32'd0);
`endif
        @(negedge QClk); RstQnnnL = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mo_no_stale", RingOutValid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
